// File: rtl/square_motion_ctrl_if.sv
// square_motion_ctrl_if: frame-start/control inputs and position/status outputs of the square sequencer
interface square_motion_ctrl_if;
  logic       frame_start;
  logic       run;
  logic [2:0] speed;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       dir_x;
  logic       dir_y;
  logic       bounce;
  logic       busy;
  logic [7:0] bounce_cnt;
  modport master (
    output frame_start, run, speed,
    input  x_pos, y_pos, dir_x, dir_y, bounce, busy, bounce_cnt
  );
  modport slave (
    input  frame_start, run, speed,
    output x_pos, y_pos, dir_x, dir_y, bounce, busy, bounce_cnt
  );
endinterface

// File: rtl/square_motion_ctrl.sv
// square_motion_ctrl: per-frame bouncing-square sequencer; ports clk, rst (sync active-high), bus (slave: frame_start/run/speed in; x_pos/y_pos/dir_x/dir_y/bounce/busy/bounce_cnt out); BOUNCE_CNT_EN builds the saturating bounce counter
module square_motion_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int SIZE   = 16,
  parameter int X_INIT = 100,
  parameter int Y_INIT = 100
) (
  input logic              clk,
  input logic              rst,
  square_motion_ctrl_if.slave bus
);
  localparam logic [10:0] X_MAX = 11'(H_RES - SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_RES - SIZE);
  typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y} state_t;
  state_t      state, next_state;
  logic [2:0]  spd;
  logic [9:0]  x, y;
  logic        dx, dy, bnc, busy, start, upd_y, d, hit;
  logic [10:0] p, m, s, sum, np;
  logic        unused_np_msb;
  assign start = bus.frame_start && bus.run && bus.speed != 3'd0;
  always_ff @(posedge clk)
    state <= rst ? IDLE : next_state;
  always_comb
    next_state = state == IDLE ? (start ? UPD_X : IDLE) :
                 state == UPD_X ? UPD_Y : IDLE;
  always_comb
    busy = state != IDLE;
  // One shared step adder: X operands in UPD_X, Y operands in UPD_Y.
  always_comb begin
    upd_y = state == UPD_Y;
    p     = {1'b0, upd_y ? y : x};
    d     = upd_y ? dy : dx;
    m     = upd_y ? Y_MAX : X_MAX;
    s     = 11'(spd);
    sum   = d ? p + s : p - s;
    hit   = d ? sum >= m : p <= s;
    np    = hit ? (d ? m : 11'd0) : sum;
  end
  assign unused_np_msb = np[10];
  always_ff @(posedge clk)
    if (rst) begin
      x   <= 10'(X_INIT);
      y   <= 10'(Y_INIT);
      dx  <= 1'b1;
      dy  <= 1'b1;
      bnc <= 1'b0;
      spd <= 3'd0;
    end else begin
      bnc <= busy && hit;
      if (state == IDLE && start) spd <= bus.speed;
      if (state == UPD_X) begin
        x  <= np[9:0];
        dx <= dx ^ hit;
      end
      if (state == UPD_Y) begin
        y  <= np[9:0];
        dy <= dy ^ hit;
      end
    end
`ifdef BOUNCE_CNT_EN
  logic [7:0] cnt;
  // Counts alongside each flipping update, so it advances with the bounce pulse.
  always_ff @(posedge clk)
    if (rst) cnt <= 8'd0;
    else if (busy && hit && cnt != 8'hff) cnt <= cnt + 8'd1;
  assign bus.bounce_cnt = cnt;
`else
  assign bus.bounce_cnt = 8'd0;
`endif
  assign bus.x_pos  = x;
  assign bus.y_pos  = y;
  assign bus.dir_x  = dx;
  assign bus.dir_y  = dy;
  assign bus.bounce = bnc;
  assign bus.busy   = busy;
endmodule

// File: tb/tb_square_motion_ctrl.sv
// tb_square_motion_ctrl: table, directed and random checks of square_motion_ctrl against a frame-level model
module tb_square_motion_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  square_motion_ctrl_if bus ();
  square_motion_ctrl_if sb ();
  square_motion_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  square_motion_ctrl #(.H_RES(20), .V_RES(20), .SIZE(16), .X_INIT(0), .Y_INIT(0))
    dut_small (.clk(clk), .rst(rst), .bus(sb));
  int errors = 0;
  int checks = 0;
  int mx, my, mc;
  bit mdx, mdy;
  typedef struct {
    bit r;
    int sp;
    int ex;
    int ey;
  } vec_t;
  vec_t tbl [6];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int exp_cnt(input int c);
`ifdef BOUNCE_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction
  function automatic void step(inout int p, inout bit d, output bit b, input int m, input int s);
    b = 1'b0;
    if (d) begin
      if (p + s >= m) begin p = m; d = 1'b0; b = 1'b1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 1'b1; b = 1'b1; end
      else p = p - s;
    end
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    bus.frame_start = 1'b0;
    sb.frame_start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    mx = 100; my = 100; mdx = 1'b1; mdy = 1'b1; mc = 0;
  endtask
  task automatic frame(input bit r, input int sp, input bit noise);
    bit go, bx, by;
    int nx, ny;
    bit ndx, ndy;
    go = r && sp != 0;
    nx = mx; ny = my; ndx = mdx; ndy = mdy; bx = 0; by = 0;
    if (go) begin
      step(nx, ndx, bx, 624, sp);
      step(ny, ndy, by, 464, sp);
    end
    @(posedge clk) #1;
    bus.run = r; bus.speed = 3'(sp); bus.frame_start = 1'b1;
    @(posedge clk) #1;
    bus.frame_start = 1'b0;
    if (noise && go) begin
      bus.frame_start = 1'b1;
      bus.run = 1'($urandom);
      bus.speed = 3'($urandom);
    end
    chk("busy_c1", int'(bus.busy), int'(go));
    chk("x_hold_c1", int'(bus.x_pos), mx);
    @(posedge clk) #1;
    bus.frame_start = 1'b0;
    chk("busy_c2", int'(bus.busy), int'(go));
    chk("x_c2", int'(bus.x_pos), nx);
    chk("dir_x_c2", int'(bus.dir_x), int'(ndx));
    chk("y_hold_c2", int'(bus.y_pos), my);
    chk("bounce_x", int'(bus.bounce), int'(bx));
    @(posedge clk) #1;
    chk("busy_c3", int'(bus.busy), 0);
    chk("y_c3", int'(bus.y_pos), ny);
    chk("dir_y_c3", int'(bus.dir_y), int'(ndy));
    chk("bounce_y", int'(bus.bounce), int'(by));
    mx = nx; my = ny; mdx = ndx; mdy = ndy;
    mc = mc + int'(bx) + int'(by);
    if (mc > 255) mc = 255;
    chk("bounce_cnt", int'(bus.bounce_cnt), exp_cnt(mc));
  endtask
  initial begin
    int px, py, sx, sy, tot;
    bit sdx, sdy, b1, b2;
    tbl[0] = '{1'b1, 4, 104, 104};
    tbl[1] = '{1'b0, 4, 104, 104};
    tbl[2] = '{1'b1, 0, 104, 104};
    tbl[3] = '{1'b1, 7, 111, 111};
    tbl[4] = '{1'b1, 1, 112, 112};
    tbl[5] = '{1'b1, 4, 116, 116};
    bus.run = 1'b0; bus.speed = 3'd0; bus.frame_start = 1'b0;
    sb.run = 1'b0; sb.speed = 3'd0; sb.frame_start = 1'b0;
    do_reset();
    chk("rst_x", int'(bus.x_pos), 100);
    chk("rst_y", int'(bus.y_pos), 100);
    chk("rst_dir_x", int'(bus.dir_x), 1);
    chk("rst_dir_y", int'(bus.dir_y), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_bounce", int'(bus.bounce), 0);
    chk("rst_cnt", int'(bus.bounce_cnt), 0);
    foreach (tbl[i]) begin
      frame(tbl[i].r, tbl[i].sp, 1'b0);
      chk("tbl_x", int'(bus.x_pos), tbl[i].ex);
      chk("tbl_y", int'(bus.y_pos), tbl[i].ey);
    end
    do_reset();
    for (int i = 1; i <= 131; i++) begin
      frame(1'b1, 4, 1'b0);
      if (i == 91) begin
        chk("edge_y_464", int'(bus.y_pos), 464);
        chk("edge_dir_y", int'(bus.dir_y), 0);
      end
    end
    chk("edge_x_624", int'(bus.x_pos), 624);
    chk("edge_dir_x", int'(bus.dir_x), 0);
    frame(1'b1, 4, 1'b0);
    chk("after_bounce_x", int'(bus.x_pos), 620);
    for (int i = 0; i < 3; i++) frame(1'b1, 4, 1'b1);
    px = mx; py = my;
    for (int i = 0; i < 10; i++) frame(1'b0, 5, 1'b0);
    for (int i = 0; i < 10; i++) frame(1'b1, 0, 1'b0);
    chk("hold_x", int'(bus.x_pos), px);
    chk("hold_y", int'(bus.y_pos), py);
    @(posedge clk) #1;
    bus.run = 1'b1; bus.speed = 3'd4; bus.frame_start = 1'b1;
    @(posedge clk) #1;
    bus.frame_start = 1'b0; rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    chk("midrst_x", int'(bus.x_pos), 100);
    chk("midrst_y", int'(bus.y_pos), 100);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_dir_x", int'(bus.dir_x), 1);
    @(posedge clk) #1;
    chk("midrst_x_stay", int'(bus.x_pos), 100);
    chk("midrst_busy_stay", int'(bus.busy), 0);
    mx = 100; my = 100; mdx = 1'b1; mdy = 1'b1; mc = 0;
    for (int i = 0; i < 200; i++)
      frame($urandom_range(0, 3) != 0, $urandom_range(0, 7), 1'($urandom));
    sx = 0; sy = 0; sdx = 1'b1; sdy = 1'b1; tot = 0;
    sb.run = 1'b1; sb.speed = 3'd7;
    for (int i = 1; i <= 160; i++) begin
      @(posedge clk) #1 sb.frame_start = 1'b1;
      @(posedge clk) #1 sb.frame_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      step(sx, sdx, b1, 4, 7);
      step(sy, sdy, b2, 4, 7);
      tot = tot + int'(b1) + int'(b2);
      if (i == 50 || i == 128 || i == 160)
        chk("small_cnt", int'(sb.bounce_cnt), exp_cnt(tot > 255 ? 255 : tot));
    end
    chk("small_x", int'(sb.x_pos), sx);
    chk("small_y", int'(sb.y_pos), sy);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
